// File: rtl/reg_access_arbiter_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// reg_access_arbiter_if : one requester channel (req/cmd in, ack/rdata back)
// Rev 1.0
// ---------------------------------------------------------------------------
interface reg_access_arbiter_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
);
  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              ack;
  logic [DATA_W-1:0] rdata;

  modport master (output req, we, addr, wdata, input  ack, rdata);
  modport slave  (input  req, we, addr, wdata, output ack, rdata);
endinterface
`default_nettype wire

// File: rtl/reg_access_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// reg_access_arbiter : two-master round-robin arbiter for the register port
// Rev 1.0 -- define ARB_FIXED_PRIO_EN for fixed priority (A over B)
// ---------------------------------------------------------------------------
module reg_access_arbiter #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32,
  parameter int RD_LAT = 1
) (
  input  wire logic              clk,
  input  wire logic              rst_n,
  reg_access_arbiter_if.slave    a_if,
  reg_access_arbiter_if.slave    b_if,
  output logic [ADDR_W-1:0]      o_reg_addr,
  output logic [DATA_W-1:0]      o_reg_wdata,
  output logic                   o_reg_write,
  output logic                   o_reg_read,
  input  wire logic [DATA_W-1:0] i_reg_rdata,
  output logic                   o_busy,
  output logic                   o_grant_id
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_WAIT  = 3'd2,
    S_DONE  = 3'd3,
    S_GAP   = 3'd4
  } state_t;

  state_t            r_state;
  logic [3:0]        r_cnt;
  logic              r_we;
  logic              r_grant_id;
  logic [ADDR_W-1:0] r_reg_addr;
  logic [DATA_W-1:0] r_reg_wdata;
  logic              r_reg_write;
  logic              r_reg_read;
  logic              r_busy;
  logic              r_a_ack;
  logic              r_b_ack;
  logic [DATA_W-1:0] r_a_rdata;
  logic [DATA_W-1:0] r_b_rdata;
`ifndef ARB_FIXED_PRIO_EN
  logic              r_last_grant;
`endif

  logic              w_any_req;
  logic              w_pick_b;
  logic              w_win_we;
  logic [ADDR_W-1:0] w_win_addr;
  logic [DATA_W-1:0] w_win_wdata;

  always_comb begin
    w_any_req = a_if.req | b_if.req;
`ifdef ARB_FIXED_PRIO_EN
    w_pick_b  = ~a_if.req;
`else
    // On a tie the master that did not win last time gets the port.
    w_pick_b  = b_if.req & (~a_if.req | ~r_last_grant);
`endif
    w_win_we    = w_pick_b ? b_if.we    : a_if.we;
    w_win_addr  = w_pick_b ? b_if.addr  : a_if.addr;
    w_win_wdata = w_pick_b ? b_if.wdata : a_if.wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_cnt        <= 4'd0;
      r_we         <= 1'b0;
      r_grant_id   <= 1'b0;
      r_reg_addr   <= '0;
      r_reg_wdata  <= '0;
      r_reg_write  <= 1'b0;
      r_reg_read   <= 1'b0;
      r_busy       <= 1'b0;
      r_a_ack      <= 1'b0;
      r_b_ack      <= 1'b0;
      r_a_rdata    <= '0;
      r_b_rdata    <= '0;
`ifndef ARB_FIXED_PRIO_EN
      r_last_grant <= 1'b1;
`endif
    end else begin
      r_reg_write <= 1'b0;
      r_reg_read  <= 1'b0;
      r_a_ack     <= 1'b0;
      r_b_ack     <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_any_req) begin
            r_grant_id   <= w_pick_b;
`ifndef ARB_FIXED_PRIO_EN
            r_last_grant <= w_pick_b;
`endif
            r_we         <= w_win_we;
            r_reg_addr   <= w_win_addr;
            r_reg_wdata  <= w_win_wdata;
            // Strobes are registered here so they are high exactly during ISSUE.
            r_reg_write  <= w_win_we;
            r_reg_read   <= ~w_win_we;
            r_busy       <= 1'b1;
            r_state      <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (r_we) begin
            r_a_ack <= ~r_grant_id;
            r_b_ack <= r_grant_id;
            r_state <= S_DONE;
          end else begin
            r_cnt   <= 4'(RD_LAT);
            r_state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (r_cnt == 4'd1) begin
            if (r_grant_id) r_b_rdata <= i_reg_rdata;
            else            r_a_rdata <= i_reg_rdata;
            r_a_ack <= ~r_grant_id;
            r_b_ack <= r_grant_id;
            r_cnt   <= 4'd0;
            r_state <= S_DONE;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        S_DONE: begin
          r_state <= S_GAP;
        end
        S_GAP: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign a_if.ack    = r_a_ack;
  assign a_if.rdata  = r_a_rdata;
  assign b_if.ack    = r_b_ack;
  assign b_if.rdata  = r_b_rdata;
  assign o_reg_addr  = r_reg_addr;
  assign o_reg_wdata = r_reg_wdata;
  assign o_reg_write = r_reg_write;
  assign o_reg_read  = r_reg_read;
  assign o_busy      = r_busy;
  assign o_grant_id  = r_grant_id;

endmodule
`default_nettype wire

// File: doc/reg_access_arbiter.md
Name: reg_access_arbiter

Overview:
- Shares the single register-file access port between two masters: the SPI slave front-end (master A) and the internal panel sequencer (master B).
- Arbitrates between them, latches the winning command, and issues one-cycle reg_write or reg_read strobes.
- Waits a fixed read latency, then returns read data and an acknowledge to the winner.
- Sits between the SPI slave / sequencer and the register bank.

Parameters:
- ADDR_W, 8, register address width.
- DATA_W, 32, register data width.
- RD_LAT, 1, cycles from the reg_read strobe to valid reg_rdata; legal range 1..15.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- a_req  in  1  master A request; held high until a_ack
- a_we  in  1  master A: 1 = write, 0 = read
- a_addr  in  ADDR_W  master A address
- a_wdata  in  DATA_W  master A write data
- a_ack  out  1  master A completion, one-cycle pulse
- a_rdata  out  DATA_W  master A read data, valid when a_ack is high after a read
- b_req, b_we, b_addr, b_wdata, b_ack, b_rdata  (same as master A, for master B)
- reg_addr  out  ADDR_W  address to the register bank
- reg_wdata  out  DATA_W  write data to the register bank
- reg_write  out  1  write strobe, one cycle
- reg_read  out  1  read strobe, one cycle
- reg_rdata  in  DATA_W  read data from the register bank
- busy  out  1  high in every state except IDLE
- grant_id  out  1  0 = A, 1 = B; the current or last grant

Behaviour:
- Reset: rst_n is asynchronous, active-low; clk is the clock. During reset:
  - all outputs are 0;
  - state is IDLE and the wait counter is 0;
  - last_grant = B, so A wins the first tie.
- States: IDLE, ISSUE, WAIT, DONE, GAP.
- IDLE:
  - Requests are sampled only in IDLE.
  - If any req is high: pick the winner, latch its we/addr/wdata into reg_addr/reg_wdata, set grant_id, go to ISSUE.
  - If no req is high: stay in IDLE.
- Arbitration: with one request, that master wins. With both, the master not equal to last_grant wins (round-robin). last_grant updates on grant.
- ISSUE (one cycle):
  - Write: reg_write = 1, go to DONE.
  - Read: reg_read = 1, load wait counter with RD_LAT, go to WAIT.
- WAIT: decrement the counter each cycle. When the counter reaches 1, capture reg_rdata into the winner's rdata register and go to DONE.
- DONE (one cycle): winner's ack = 1, go to GAP.
- GAP (one cycle): no arbitration. The acked master drops req during this cycle. Go to IDLE.
- Latency, with req seen in IDLE at cycle 0:
  - write: strobe at cycle 1, ack at cycle 2;
  - read: strobe at cycle 1, ack at cycle 2 + RD_LAT.
  - Minimum request-to-request spacing: 4 cycles for a write, 4 + RD_LAT cycles for a read.
- Held values:
  - reg_addr/reg_wdata stay stable from ISSUE until the next grant.
  - a_rdata/b_rdata hold the last read value; writes leave them unchanged.
  - The loser's rdata is never modified.
- Command latching: changes to a master's we/addr/wdata after grant are ignored for that transaction.
- Request withdrawal: a req that drops before it is granted is simply not serviced. A granted transaction always completes.
- Strobes: reg_write and reg_read are never high together, and never high outside ISSUE.
- Reset mid-transaction: aborts immediately with no ack and no further strobes; the next grant again starts round-robin with A.

Optional Feature:
- Macro ARB_FIXED_PRIO_EN.
- Defined: A always wins when both masters request; last_grant is unused.
- Undefined: round-robin as described in Behaviour.
- Neither setting changes latency.

Test Plan:
- Write, A only: a_req=1, a_we=1, a_addr=0x12, a_wdata=0xDEADBEEF. Required: reg_write at cycle 1 with reg_addr=0x12 and reg_wdata=0xDEADBEEF; a_ack at cycle 2; b_ack stays 0.
- Read, B only, RD_LAT=3: bank returns 0xCAFE0001 for addr 0x40. Required: reg_read at cycle 1, b_ack at cycle 5, b_rdata=0xCAFE0001, a_rdata unchanged.
- Simultaneous requests held continuously (A write, B write), round-robin: grant order A, B, A, B; each ack exactly one cycle; exactly one reg_write per grant.
- Same simultaneous requests with ARB_FIXED_PRIO_EN: A is granted every time while a_req is re-asserted after each GAP; B waits; B is granted once A idles.
- Command latching: A read granted, then a_addr changed to 0x55 during WAIT. Required: reg_addr stays at the originally latched value and the read completes normally.
- Reset mid-transaction: rst_n low during a B read in WAIT. Required: all outputs 0 immediately, no b_ack; after release, simultaneous A+B requests are granted to A first.
